dual_issue_scheduler: RTL and testbench



---
 rtl/dual_issue_scheduler_pkg.sv | 42 ++++
 rtl/dual_issue_scheduler_instr_classifier.sv | 81 ++++++++
 rtl/dual_issue_scheduler.sv | 151 +++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_scheduler_pkg.sv
// Shared opcode constants, FSM state encoding and per-slot decode record
// for the dual-issue scheduler and its instruction classifier.
package sched_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SPLIT   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic       writes_rd;
        logic       reads_rs1;
        logic       reads_rs2;
        logic       is_mem;
        logic       is_ctrl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } instr_class_t;

    // A pair must be issued over two cycles on RAW/WAW, dual memory, or slot-0 control flow.
    function automatic logic split_needed(input instr_class_t c0, input instr_class_t c1);
        logic raw;
        logic waw;
        raw = c0.writes_rd &
              ((c1.reads_rs1 & (c1.rs1 == c0.rd)) | (c1.reads_rs2 & (c1.rs2 == c0.rd)));
        waw = c0.writes_rd & c1.writes_rd & (c0.rd == c1.rd);
        return raw | waw | (c0.is_mem & c1.is_mem) | c0.is_ctrl;
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_instr_classifier.sv
// Combinational RV32I opcode decode: which registers a word reads/writes and
// whether it touches memory or redirects control flow.
module instr_classifier
    import sched_pkg::*;
(
    input  logic [31:0]  i_word,
    output instr_class_t o_cls
);

    logic       w_wr;
    logic       w_r1;
    logic       w_r2;
    logic       w_mem;
    logic       w_ctrl;
    logic [4:0] w_rd;
    logic       w_unused_fields;

    assign w_rd            = i_word[11:7];
    assign w_unused_fields = ^{i_word[31:25], i_word[14:12]};

    // Opcode to register-use/class flags; unknown opcodes stay all-zero.
    always_comb begin
        w_wr   = 1'b0;
        w_r1   = 1'b0;
        w_r2   = 1'b0;
        w_mem  = 1'b0;
        w_ctrl = 1'b0;
        case (i_word[6:0])
            OP_R: begin
                w_wr = 1'b1;
                w_r1 = 1'b1;
                w_r2 = 1'b1;
            end
            OP_IALU: begin
                w_wr = 1'b1;
                w_r1 = 1'b1;
            end
            OP_LOAD: begin
                w_wr  = 1'b1;
                w_r1  = 1'b1;
                w_mem = 1'b1;
            end
            OP_STORE: begin
                w_r1  = 1'b1;
                w_r2  = 1'b1;
                w_mem = 1'b1;
            end
            OP_BRANCH: begin
                w_r1   = 1'b1;
                w_r2   = 1'b1;
                w_ctrl = 1'b1;
            end
            OP_JAL: begin
                w_wr   = 1'b1;
                w_ctrl = 1'b1;
            end
            OP_JALR: begin
                w_wr   = 1'b1;
                w_r1   = 1'b1;
                w_ctrl = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_wr = 1'b1;
            end
            default: begin
                w_wr = 1'b0;
            end
        endcase
    end

    // x0 is never a real destination, so it can never create a hazard.
    assign o_cls.writes_rd = w_wr & (w_rd != 5'd0);
    assign o_cls.reads_rs1 = w_r1;
    assign o_cls.reads_rs2 = w_r2;
    assign o_cls.is_mem    = w_mem;
    assign o_cls.is_ctrl   = w_ctrl;
    assign o_cls.rd        = w_rd;
    assign o_cls.rs1       = i_word[19:15];
    assign o_cls.rs2       = i_word[24:20];

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue controller: issues the fetched pair together or split across two
// cycles, holds both slots during outstanding memory accesses, honours flush.
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_pin,
    input  logic             ins_valid,
    input  logic [31:0]      instruction0,
    input  logic [31:0]      instruction1,
    input  logic             mem_ready,
    input  logic             flush,
    output logic             datapath_1_enable,
    output logic             datapath_2_enable,
    output logic             freeze1,
    output logic             freeze2,
    output logic             fetch_advance,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    instr_class_t     w_cls0;
    instr_class_t     w_cls1;
    logic             w_split;
    logic             w_unused_cls;

    state_t           r_state;
    logic             r_pending;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_state_nxt;
    logic             w_pending_nxt;
    logic             w_en1;
    logic             w_en2;
    logic             w_frz1;
    logic             w_frz2;
    logic             w_adv;

    instr_classifier u_cls0 (
        .i_word (instruction0),
        .o_cls  (w_cls0)
    );

    instr_classifier u_cls1 (
        .i_word (instruction1),
        .o_cls  (w_cls1)
    );

    assign w_split      = split_needed(w_cls0, w_cls1);
    assign w_unused_cls = ^{w_cls0.reads_rs1, w_cls0.reads_rs2, w_cls0.rs1, w_cls0.rs2, w_cls1.is_ctrl};

    // Mealy issue decision and next-state selection; flush overrides everything.
    always_comb begin
        w_en1         = 1'b0;
        w_en2         = 1'b0;
        w_frz1        = 1'b0;
        w_frz2        = 1'b0;
        w_adv         = 1'b0;
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            RUN: begin
                if (!ins_valid) begin
                    w_state_nxt = RUN;
                end else if (w_split) begin
                    w_en1       = 1'b1;
                    w_frz2      = 1'b1;
                    if (w_cls0.is_mem && !mem_ready) begin
                        w_state_nxt   = MEMWAIT;
                        w_pending_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = SPLIT;
                    end
                end else begin
                    w_en1 = 1'b1;
                    w_en2 = 1'b1;
                    w_adv = 1'b1;
                    if ((w_cls0.is_mem || w_cls1.is_mem) && !mem_ready) begin
                        w_state_nxt = MEMWAIT;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            SPLIT: begin
                w_en2  = 1'b1;
                w_frz1 = 1'b1;
                w_adv  = 1'b1;
                if (w_cls1.is_mem && !mem_ready) begin
                    w_state_nxt = MEMWAIT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            MEMWAIT: begin
                w_frz1 = 1'b1;
                w_frz2 = 1'b1;
                if (mem_ready) begin
                    w_state_nxt   = r_pending ? SPLIT : RUN;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_state_nxt   = MEMWAIT;
                end
            end
            default: begin
                w_state_nxt   = RUN;
                w_pending_nxt = 1'b0;
            end
        endcase
        if (flush) begin
            w_en1         = 1'b0;
            w_en2         = 1'b0;
            w_frz1        = 1'b0;
            w_frz2        = 1'b0;
            w_adv         = 1'b1;
            w_state_nxt   = RUN;
            w_pending_nxt = 1'b0;
        end else begin
            w_adv         = w_adv;
        end
    end

    // State, deferred-split flag and saturating stall counter.
    always_ff @(posedge clk or negedge rst_pin) begin
        if (!rst_pin) begin
            r_state     <= RUN;
            r_pending   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if ((r_state != RUN) && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    // Outputs are forced low the moment reset is asserted, not at the next edge.
    assign datapath_1_enable = rst_pin & w_en1;
    assign datapath_2_enable = rst_pin & w_en2;
    assign freeze1           = rst_pin & w_frz1;
    assign freeze2           = rst_pin & w_frz2;
    assign fetch_advance     = rst_pin & w_adv;
    assign stall_count       = r_stall_cnt;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Randomised + directed bench for dual_issue_scheduler against a pair-level
// issue model; a second instance with a 2-bit counter covers saturation.
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_pin = 1'b0;
    logic        ins_valid = 1'b0;
    logic [31:0] i0 = 32'h0;
    logic [31:0] i1 = 32'h0;
    logic        mem_ready = 1'b1;
    logic        flush = 1'b0;

    logic        en1, en2, f1, f2, adv;
    logic [15:0] cnt;
    logic        b_en1, b_en2, b_f1, b_f2, b_adv;
    logic [1:0]  cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: m_wait = memory outstanding, m_held = slot 1 still owed.
    bit m_wait = 1'b0;
    bit m_held = 1'b0;
    int m_cnt16 = 0;
    int m_cnt2  = 0;

    always #5 clk = ~clk;

    dual_issue_scheduler u_dut (
        .clk(clk), .rst_pin(rst_pin), .ins_valid(ins_valid),
        .instruction0(i0), .instruction1(i1), .mem_ready(mem_ready), .flush(flush),
        .datapath_1_enable(en1), .datapath_2_enable(en2), .freeze1(f1), .freeze2(f2),
        .fetch_advance(adv), .stall_count(cnt)
    );

    dual_issue_scheduler #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_pin(rst_pin), .ins_valid(ins_valid),
        .instruction0(i0), .instruction1(i1), .mem_ready(mem_ready), .flush(flush),
        .datapath_1_enable(b_en1), .datapath_2_enable(b_en2), .freeze1(b_f1), .freeze2(b_f2),
        .fetch_advance(b_adv), .stall_count(cnt2)
    );

    // {writes_rd, reads_rs1, reads_rs2, is_mem, is_ctrl}
    function automatic logic [4:0] flags(input logic [31:0] w);
        logic [6:0] op;
        logic wr, r1, r2, mem, ctl;
        op  = w[6:0];
        wr  = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h6f) ||
              (op == 7'h67) || (op == 7'h37) || (op == 7'h17);
        wr  = wr && (w[11:7] != 5'd0);
        r1  = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) ||
              (op == 7'h63) || (op == 7'h67);
        r2  = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
        mem = (op == 7'h03) || (op == 7'h23);
        ctl = (op == 7'h63) || (op == 7'h6f) || (op == 7'h67);
        return {wr, r1, r2, mem, ctl};
    endfunction

    function automatic bit must_split(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] fa, fb;
        bit raw, waw;
        fa  = flags(a);
        fb  = flags(b);
        raw = fa[4] && ((fb[3] && b[19:15] == a[11:7]) || (fb[2] && b[24:20] == a[11:7]));
        waw = fa[4] && fb[4] && (a[11:7] == b[11:7]);
        return raw || waw || (fa[1] && fb[1]) || fa[0];
    endfunction

    // Expected {en1, en2, freeze1, freeze2, advance} for the current inputs.
    function automatic logic [4:0] model_out();
        if (!rst_pin)        return 5'b00000;
        if (flush)           return 5'b00001;
        if (m_wait)          return 5'b00110;
        if (m_held)          return 5'b01101;
        if (!ins_valid)      return 5'b00000;
        if (must_split(i0, i1)) return 5'b10010;
        return 5'b11001;
    endfunction

    // Model advance on each clock; reset clears it immediately.
    always @(posedge clk or negedge rst_pin) begin
        if (!rst_pin) begin
            m_wait = 1'b0; m_held = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
        end else begin
            if (m_wait || m_held) begin
                if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
                if (m_cnt2 < 3)      m_cnt2  = m_cnt2 + 1;
            end
            if (flush) begin
                m_wait = 1'b0; m_held = 1'b0;
            end else if (m_wait) begin
                if (mem_ready) m_wait = 1'b0;
            end else if (m_held) begin
                m_held = 1'b0;
                m_wait = flags(i1)[1] && !mem_ready;
            end else if (ins_valid) begin
                if (must_split(i0, i1)) begin
                    m_held = 1'b1;
                    m_wait = flags(i0)[1] && !mem_ready;
                end else begin
                    m_wait = (flags(i0)[1] || flags(i1)[1]) && !mem_ready;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    endtask

    task automatic check_model();
        logic [4:0] e;
        e = model_out();
        chk("outs",  {27'd0, en1, en2, f1, f2, adv}, {27'd0, e});
        chk("cnt",   {16'd0, cnt}, m_cnt16);
        chk("outs2", {27'd0, b_en1, b_en2, b_f1, b_f2, b_adv}, {27'd0, e});
        chk("cnt2",  {30'd0, cnt2}, m_cnt2);
    endtask

    task automatic apply(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic mr, input logic fl);
        @(negedge clk);
        rst_pin = r; ins_valid = v; i0 = a; i1 = b; mem_ready = mr; flush = fl;
        #2;
        check_model();
    endtask

    task automatic lit(input string name, input logic [4:0] e, input int ecnt);
        chk(name, {27'd0, en1, en2, f1, f2, adv}, {27'd0, e});
        chk({name, "_cnt"}, {16'd0, cnt}, ecnt);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        logic [31:0] a, b;
        #2;
        check_model();
        lit("reset", 5'b00000, 0);
        apply(1'b0, 1'b1, 32'h00500093, 32'h00100193, 1'b1, 1'b0);
        lit("reset_held", 5'b00000, 0);

        apply(1'b1, 1'b1, 32'h00500093, 32'h00100193, 1'b1, 1'b0);
        lit("indep", 5'b11001, 0);

        apply(1'b1, 1'b1, 32'h00500093, 32'h00108133, 1'b1, 1'b0);
        lit("raw_n", 5'b10010, 0);
        apply(1'b1, 1'b1, 32'h00500093, 32'h00108133, 1'b1, 1'b0);
        lit("raw_n1", 5'b01101, 0);
        apply(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        lit("raw_done", 5'b00000, 1);

        apply(1'b1, 1'b1, 32'h00002203, 32'h00402223, 1'b0, 1'b0);
        lit("mem_n", 5'b10010, 1);
        apply(1'b1, 1'b1, 32'h00002203, 32'h00402223, 1'b0, 1'b0);
        lit("mem_w1", 5'b00110, 1);
        apply(1'b1, 1'b1, 32'h00002203, 32'h00402223, 1'b0, 1'b0);
        lit("mem_w2", 5'b00110, 2);
        apply(1'b1, 1'b1, 32'h00002203, 32'h00402223, 1'b1, 1'b0);
        lit("mem_w3", 5'b00110, 3);
        apply(1'b1, 1'b1, 32'h00002203, 32'h00402223, 1'b1, 1'b0);
        lit("mem_split", 5'b01101, 4);
        apply(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        lit("mem_done", 5'b00000, 5);

        apply(1'b1, 1'b1, 32'h00000463, 32'h00500093, 1'b1, 1'b0);
        lit("br_n", 5'b10010, 5);
        apply(1'b1, 1'b1, 32'h00000463, 32'h00500093, 1'b1, 1'b1);
        lit("br_flush", 5'b00001, 5);
        apply(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        lit("br_run", 5'b00000, 6);

        apply(1'b1, 1'b1, 32'h00002203, 32'h00100193, 1'b0, 1'b0);
        lit("rst_lw", 5'b11001, 6);
        apply(1'b1, 1'b1, 32'h00002203, 32'h00100193, 1'b0, 1'b0);
        lit("rst_wait", 5'b00110, 6);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b1, 32'h00002203, 32'h00100193, 1'b0, 1'b0);
            lit("rst_mid", 5'b00000, 0);
        end
        apply(1'b1, 1'b1, 32'h00500093, 32'h00100193, 1'b1, 1'b0);
        lit("rst_release", 5'b11001, 0);

        apply(1'b1, 1'b1, 32'h00002203, 32'h00100193, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) apply(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sat_cnt2", {30'd0, cnt2}, 32'd3);
        apply(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sat_hold", {30'd0, cnt2}, 32'd3);
        lit("sat_cnt16", 5'b00000, 6);

        for (int n = 0; n < 3000; n++) begin
            a = rand_instr();
            b = rand_instr();
            apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 85), a, b,
                  ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
